// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared types and constants for the HUB75 scan controller
// Contents:
//   state_t     scan FSM state encoding
//   CH_*        colour slice index inside rd_data = {r1,g1,b1,r0,g0,b0},
//               each slice PLANES bits wide, b0 in the lowest slice
//   disp_cnt_w  width needed to hold the longest display period BASE_ON<<(PLANES-1)
package hub75_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_BLANK,
    S_LATCH,
    S_GUARD,
    S_DISPLAY
  } state_t;

  localparam int CH_B0  = 0;
  localparam int CH_G0  = 1;
  localparam int CH_R0  = 2;
  localparam int CH_B1  = 3;
  localparam int CH_G1  = 4;
  localparam int CH_R1  = 5;
  localparam int NUM_CH = 6;

  function automatic int disp_cnt_w(input int base_on, input int planes);
    return $clog2((base_on << (planes - 1)) + 1);
  endfunction

  localparam int DISP_CNT_W = disp_cnt_w(8, 4);

endpackage

// File: rtl/hub75_bcm_timer.sv
// rtl/hub75_bcm_timer.sv - loadable down-counter timing one BCM display period
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load       load load_val and start counting
//   load_val   period length minus one
//   done       high during the final cycle of the loaded period (count reached 0)
module hub75_bcm_timer
  import hub75_pkg::*;
#(
  parameter int W = DISP_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;
  logic         active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      active <= 1'b0;
    end else if (load) begin
      count  <= load_val;
      active <= 1'b1;
    end else if (active) begin
      if (count == '0) active <= 1'b0;
      else             count  <= count - 1'b1;
    end
  end

  assign done = active && (count == '0);

endmodule

// File: rtl/hub75_scan_ctrl.sv
// rtl/hub75_scan_ctrl.sv - HUB75 row / BCM bit-plane scan scheduler
// Reads pixels from a synchronous frame buffer and drives the panel pins.
// Optional feature macro: HUB75_GHOST_BLANK_EN (BLANK lasts GUARD cycles and
// GUARD oe=1 cycles are inserted between LATCH and DISPLAY).
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   enable           run scanning (sampled in IDLE and at frame end)
//   rd_en, rd_addr   frame-buffer read strobe and {row, col} address
//   rd_data          {r1,g1,b1,r0,g0,b0}, PLANES bits each, valid 1 cycle after rd_en
//   addr             panel row address
//   oe               output enable, active low
//   latch, clk_out   panel latch strobe and shift clock
//   r0,g0,b0         top-half colour bits of the current plane
//   r1,g1,b1         bottom-half colour bits of the current plane
//   busy             state != IDLE
//   frame_done       one-cycle pulse after the last DISPLAY cycle of a frame
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int COLS    = 32,
  parameter int ADDR_W  = 4,
  parameter int PLANES  = 4,
  parameter int BASE_ON = 8,
  parameter int CLK_DIV = 2,
  parameter int GUARD   = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  output logic                             rd_en,
  output logic [ADDR_W+$clog2(COLS)-1:0]   rd_addr,
  input  logic [6*PLANES-1:0]              rd_data,
  output logic [ADDR_W-1:0]                addr,
  output logic                             oe,
  output logic                             latch,
  output logic                             clk_out,
  output logic                             r0,
  output logic                             g0,
  output logic                             b0,
  output logic                             r1,
  output logic                             g1,
  output logic                             b1,
  output logic                             busy,
  output logic                             frame_done
);

  localparam int COL_W  = $clog2(COLS);
  localparam int PL_W   = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int SLOT   = 2 * CLK_DIV;
  localparam int TICK_W = $clog2(SLOT + GUARD + 1);
  localparam int DW     = disp_cnt_w(BASE_ON, PLANES);
`ifdef HUB75_GHOST_BLANK_EN
  localparam int BLANK_LEN = GUARD;
  localparam state_t AFTER_LATCH = S_GUARD;
`else
  localparam int BLANK_LEN = 1;
  localparam state_t AFTER_LATCH = S_DISPLAY;
`endif

  state_t            state, state_n;
  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] row;
  logic [PL_W-1:0]   plane;
  // Cycle counter inside the current state: slot phase in SHIFT, length of BLANK/GUARD.
  logic [TICK_W-1:0] tick;
  logic              slot_last, col_last, plane_last, frame_last;
  logic              disp_load, disp_done;
  logic [PLANES-1:0] ch [NUM_CH];

  assign slot_last  = (tick == TICK_W'(SLOT - 1));
  assign col_last   = (col == COL_W'(COLS - 1));
  assign plane_last = (plane == PL_W'(PLANES - 1));
  assign frame_last = plane_last && (row == {ADDR_W{1'b1}});
  assign rd_addr    = {row, col};

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) ch[i] = rd_data[i*PLANES +: PLANES];
  end

  assign disp_load = (state_n == S_DISPLAY) && (state != S_DISPLAY);

  hub75_bcm_timer #(.W(DW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (disp_load),
    .load_val (DW'((BASE_ON << plane) - 1)),
    .done     (disp_done)
  );

  always_comb begin
    state_n = state;
    rd_en   = 1'b0;
    oe      = 1'b1;
    latch   = 1'b0;
    clk_out = 1'b0;
    busy    = (state != S_IDLE);
    case (state)
      S_IDLE:    if (enable) state_n = S_SHIFT;
      S_SHIFT: begin
        rd_en   = (tick == '0);
        clk_out = (tick >= TICK_W'(CLK_DIV));
        if (slot_last && col_last) state_n = S_BLANK;
      end
      S_BLANK:   if (tick == TICK_W'(BLANK_LEN - 1)) state_n = S_LATCH;
      S_LATCH: begin
        latch   = 1'b1;
        state_n = AFTER_LATCH;
      end
      S_GUARD:   if (tick == TICK_W'(GUARD - 1)) state_n = S_DISPLAY;
      S_DISPLAY: begin
        oe = 1'b0;
        // enable only matters at the frame boundary; mid-frame the scan always continues
        if (disp_done) state_n = (frame_last && !enable) ? S_IDLE : S_SHIFT;
      end
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      plane      <= '0;
      tick       <= '0;
      addr       <= '0;
      frame_done <= 1'b0;
      {r1, g1, b1, r0, g0, b0} <= '0;
    end else begin
      state      <= state_n;
      frame_done <= 1'b0;
      if ((state_n != state) || (state == S_SHIFT && slot_last)) tick <= '0;
      else                                                       tick <= tick + 1'b1;
      if (state == S_SHIFT && slot_last) col <= col + 1'b1;
      // rd_data answers the read issued in slot cycle 0
      if (state == S_SHIFT && tick == TICK_W'(1)) begin
        r1 <= ch[CH_R1][plane];
        g1 <= ch[CH_G1][plane];
        b1 <= ch[CH_B1][plane];
        r0 <= ch[CH_R0][plane];
        g0 <= ch[CH_G0][plane];
        b0 <= ch[CH_B0][plane];
      end
      if (state == S_SHIFT && state_n == S_BLANK) addr <= row;
      if (state == S_DISPLAY && disp_done) begin
        if (plane_last) begin
          plane <= '0;
          row   <= row + 1'b1;
          if (frame_last) frame_done <= 1'b1;
        end else begin
          plane <= plane + 1'b1;
        end
      end
    end
  end

endmodule
